// File: rtl/wide_mag_comp_seq.sv
// Sequential magnitude comparator for WIDTH-bit unsigned operands.
// One 4-bit slice is reused per cycle, MSB nibble first, stopping at the first unequal nibble.
module wide_mag_comp_seq #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4,
  parameter int CW    = $clog2(NIB + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    nib_cnt
);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("wide_mag_comp_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_n;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [CW-1:0]    idx_r;
  logic [CW-1:0]    count_r;
  logic             busy_r;
  logic             done_r;
  logic             eq_r;
  logic             gt_r;
  logic             lt_r;
  logic [CW-1:0]    nib_cnt_r;
  logic [3:0]       nib_a_s;
  logic [3:0]       nib_b_s;
  logic [1:0]       slice_s;
  logic             slice_eq_s;

  // 4-bit slice: per-bit XNOR equality, the first differing bit from the MSB decides {gt,lt}.
  function automatic logic [1:0] nib_cmp(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] same;
    logic [1:0] res;
    logic       found;
    same  = a ~^ b;
    res   = 2'b00;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (!found && !same[i]) begin
        found = 1'b1;
        res   = a[i] ? 2'b10 : 2'b01;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  // Nibble select for the current index, feeding the shared slice.
  always_comb begin
    nib_a_s = 4'h0;
    nib_b_s = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx_r == CW'(i)) begin
        nib_a_s = op_a_r[4*i +: 4];
        nib_b_s = op_b_r[4*i +: 4];
      end else begin
        nib_a_s = nib_a_s;
        nib_b_s = nib_b_s;
      end
    end
    slice_s    = nib_cmp(nib_a_s, nib_b_s);
    slice_eq_s = (slice_s == 2'b00);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic; abort only matters while comparing and wins over a resolving nibble.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_n = CMP;
        else       state_n = IDLE;
      end
      CMP: begin
        if (abort)                               state_n = IDLE;
        else if (!slice_eq_s || idx_r == '0)     state_n = DONE;
        else                                     state_n = CMP;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand capture, nibble walk and result registers; results move only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r    <= '0;
      op_b_r    <= '0;
      idx_r     <= '0;
      count_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      eq_r      <= 1'b0;
      gt_r      <= 1'b0;
      lt_r      <= 1'b0;
      nib_cnt_r <= '0;
    end else begin
      busy_r <= (state_n != IDLE);
      done_r <= (state_n == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            op_a_r  <= in_a;
            op_b_r  <= in_b;
            idx_r   <= CW'(NIB - 1);
            count_r <= '0;
          end
        end
        CMP: begin
          if (!abort) begin
            count_r <= count_r + CW'(1);
            if (!slice_eq_s) begin
              eq_r      <= 1'b0;
              gt_r      <= slice_s[1];
              lt_r      <= slice_s[0];
              nib_cnt_r <= count_r + CW'(1);
            end else if (idx_r == '0) begin
              eq_r      <= 1'b1;
              gt_r      <= 1'b0;
              lt_r      <= 1'b0;
              nib_cnt_r <= CW'(NIB);
            end else begin
              idx_r <= idx_r - CW'(1);
            end
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign eq      = eq_r;
  assign gt      = gt_r;
  assign lt      = lt_r;
  assign nib_cnt = nib_cnt_r;

endmodule
